// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register, +PC_STEP adder and a small fixed instruction ROM.
// The PC only advances on clock edges where the debugger step enable is held high.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 64,
  parameter int                    PC_STEP    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  buttonPress,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] newAddr,
  output logic [DATA_WIDTH-1:0] instruction
);

  localparam int         IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [3:0] ALU_ADD = 4'b0010;

  localparam logic [DATA_WIDTH-1:0] ROM_INIT [0:7] = '{
    32'h20080005,
    32'h2009000A,
    32'h01095020,
    32'h01095822,
    32'h01096024,
    32'h01096825,
    32'h0109702A,
    32'h08000000
  };

  // Shared ALU datapath, tied to add; wraps modulo 2^ADDR_WIDTH with no carry out.
  function automatic logic [ADDR_WIDTH-1:0] alu(
    input logic [3:0]            ctrl,
    input logic [ADDR_WIDTH-1:0] a,
    input logic [ADDR_WIDTH-1:0] b
  );
    case (ctrl)
      ALU_ADD: alu = a + b;
      default: alu = '0;
    endcase
  endfunction

  logic [IDX_W-1:0]      word_idx;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rom_word;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      addr <= RESET_ADDR;
    end else if (buttonPress) begin
      addr <= newAddr;
    end
  end

  assign newAddr = alu(ALU_ADD, addr, ADDR_WIDTH'(PC_STEP));

  // Byte offset bits are dropped so a misaligned PC reads its containing word.
  assign word_idx = addr[IDX_W+1:2];
  assign in_range = (addr >> (IDX_W + 2)) == '0;

  always_comb begin
    rom_word = '0;
    if ((word_idx >> 3) == '0) begin
      rom_word = ROM_INIT[word_idx[2:0]];
    end
  end

  assign instruction = (Rst || !in_range) ? '0 : rom_word;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: three instances (reset address 0, 0xFFFFFFFC, 0x6)
// share one stimulus; a PC/ROM model is compared every cycle, plus literal spot values.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        buttonPress = 1'b0;
  logic [31:0] a0, a1, a2;
  logic [31:0] na0, na1, na2;
  logic [31:0] ins0, ins1, ins2;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [31:0] m_pc [3];
  logic [31:0] rv [3];
  logic [31:0] rom_m [64];
  logic [31:0] exp_ss [4];

  always #5 Clk = ~Clk;

  instruction_fetch_unit u0 (
    .Clk(Clk), .Rst(Rst), .buttonPress(buttonPress),
    .addr(a0), .newAddr(na0), .instruction(ins0)
  );

  instruction_fetch_unit #(.RESET_ADDR(32'hFFFFFFFC)) u1 (
    .Clk(Clk), .Rst(Rst), .buttonPress(buttonPress),
    .addr(a1), .newAddr(na1), .instruction(ins1)
  );

  instruction_fetch_unit #(.RESET_ADDR(32'h00000006)) u2 (
    .Clk(Clk), .Rst(Rst), .buttonPress(buttonPress),
    .addr(a2), .newAddr(na2), .instruction(ins2)
  );

  initial begin
    for (int i = 0; i < 64; i++) rom_m[i] = 32'h0;
    rom_m[0] = 32'h20080005;
    rom_m[1] = 32'h2009000A;
    rom_m[2] = 32'h01095020;
    rom_m[3] = 32'h01095822;
    rom_m[4] = 32'h01096024;
    rom_m[5] = 32'h01096825;
    rom_m[6] = 32'h0109702A;
    rom_m[7] = 32'h08000000;
    rv[0] = 32'h00000000;
    rv[1] = 32'hFFFFFFFC;
    rv[2] = 32'h00000006;
    exp_ss[0] = 32'h2009000A;
    exp_ss[1] = 32'h01095020;
    exp_ss[2] = 32'h01095822;
    exp_ss[3] = 32'h01096024;
  end

  function automatic logic [31:0] exp_ins(input logic [31:0] pc, input logic r);
    if (r) return 32'h0;
    if (pc >= 32'd256) return 32'h0;
    return rom_m[pc / 4];
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference PC per instance: reset value, otherwise +4 per enabled edge.
  always @(posedge Clk) begin
    for (int i = 0; i < 3; i++) begin
      if (Rst) m_pc[i] <= rv[i];
      else if (buttonPress) m_pc[i] <= m_pc[i] + 32'd4;
    end
  end

  always @(posedge Clk) begin
    #3;
    if (started) begin
      cmp("addr_u0", a0, m_pc[0]);
      cmp("newaddr_u0", na0, m_pc[0] + 32'd4);
      cmp("instr_u0", ins0, exp_ins(m_pc[0], Rst));
      cmp("addr_u1", a1, m_pc[1]);
      cmp("newaddr_u1", na1, m_pc[1] + 32'd4);
      cmp("instr_u1", ins1, exp_ins(m_pc[1], Rst));
      cmp("addr_u2", a2, m_pc[2]);
      cmp("newaddr_u2", na2, m_pc[2] + 32'd4);
      cmp("instr_u2", ins2, exp_ins(m_pc[2], Rst));
    end
  end

  task automatic step(input logic r, input logic b, input int n);
    repeat (n) begin
      @(negedge Clk);
      Rst = r;
      buttonPress = b;
      @(posedge Clk);
    end
    #1;
  endtask

  initial begin
    step(1'b1, 1'b0, 1);
    started = 1'b1;
    cmp("rst_addr", a0, 32'h0);
    cmp("rst_newaddr", na0, 32'h4);
    cmp("rst_instr", ins0, 32'h0);

    step(1'b0, 1'b0, 1);
    cmp("post_rst_instr", ins0, 32'h20080005);
    cmp("wrap_pre_addr", a1, 32'hFFFFFFFC);
    cmp("wrap_pre_newaddr", na1, 32'h0);
    cmp("wrap_pre_instr", ins1, 32'h0);
    cmp("mis_instr", ins2, 32'h2009000A);

    step(1'b0, 1'b0, 3);
    cmp("hold_addr", a0, 32'h0);
    cmp("hold_instr", ins0, 32'h20080005);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1);
      cmp("ss_addr", a0, 32'(4 * (i + 1)));
      cmp("ss_instr", ins0, exp_ss[i]);
      if (i == 0) begin
        cmp("wrap_addr", a1, 32'h0);
        cmp("wrap_instr", ins1, 32'h20080005);
        cmp("mis_step_addr", a2, 32'h0000000A);
        cmp("mis_step_instr", ins2, 32'h01095020);
      end
      step(1'b0, 1'b0, 3);
    end

    step(1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 8);
    cmp("cont_addr", a0, 32'd32);
    cmp("cont_instr", ins0, 32'h0);
    step(1'b0, 1'b1, 56);
    cmp("beyond_addr", a0, 32'd256);
    cmp("beyond_instr", ins0, 32'h0);

    step(1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 5);
    cmp("pri_pre_addr", a0, 32'd20);
    cmp("pri_pre_instr", ins0, 32'h01096825);
    step(1'b1, 1'b1, 1);
    cmp("pri_addr", a0, 32'h0);
    cmp("pri_instr", ins0, 32'h0);
    step(1'b0, 1'b1, 1);
    cmp("pri_next_addr", a0, 32'h4);

    step(1'b0, 1'b0, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Instruction-fetch stage of the unpipelined processor: program counter register, +4 adder, and word-addressed instruction ROM in one block.
- PC advances only while the step enable (debugger button) is high, giving single-step fetch under debugger control.
- Outputs the current PC, next sequential PC and fetched instruction word to the decode stage and debugger.

Parameters:
- ADDR_WIDTH, 32, PC / address width in bits.
- DATA_WIDTH, 32, instruction word width.
- MEM_DEPTH, 64, number of 32-bit ROM words (byte addresses 0 .. 4*MEM_DEPTH-4).
- PC_STEP, 4, constant added to PC per step.
- RESET_ADDR, 0, PC value loaded on reset.

Ports:
- Clk, input, 1, system clock; all state updates on rising edge.
- Rst, input, 1, synchronous, active-high reset.
- buttonPress, input, 1, step enable: PC loads next address on a rising Clk edge while high.
- addr, output, ADDR_WIDTH, current PC (registered).
- newAddr, output, ADDR_WIDTH, next sequential address = addr + PC_STEP (combinational).
- instruction, output, DATA_WIDTH, ROM word at addr (combinational).

Behaviour:
- Reset: one clock is the only clock. On a rising Clk edge with Rst=1, addr <= RESET_ADDR (0). Rst overrides buttonPress. While Rst=1, instruction is forced to 32'h00000000. After the reset edge, newAddr = 4.
- PC update, evaluated at each rising Clk edge with Rst=0:
  - buttonPress=1: addr <= newAddr.
  - buttonPress=0: addr holds.
- buttonPress is level-sensitive with no edge detection: high for N rising edges gives N increments (addr += 4N).
- Adder: 32-bit ALU restricted to add (ALU control 4'b0010) with constant operand PC_STEP.
  - Unsigned modulo 2^32: addr = 32'hFFFFFFFC gives newAddr = 32'h00000000.
  - No carry or overflow output.
  - Latency 0, combinational from addr.
- ROM:
  - Asynchronous read; word index = addr[7:2] for MEM_DEPTH=64 (generally addr[log2(MEM_DEPTH)+1:2]).
  - addr[1:0] ignored, so misaligned addresses read the containing word.
  - Any addr >= 4*MEM_DEPTH returns 32'h00000000. No wrap into the ROM.
  - instruction updates in the same cycle addr changes.
- ROM contents, fixed at synthesis:
  - w0 = 32'h20080005
  - w1 = 32'h2009000A
  - w2 = 32'h01095020
  - w3 = 32'h01095822
  - w4 = 32'h01096024
  - w5 = 32'h01096825
  - w6 = 32'h0109702A
  - w7 = 32'h08000000
  - w8..w63 = 32'h00000000
- Reset mid-operation: a reset edge with buttonPress=1 yields addr=0, not an increment. The first increment happens at the next non-reset edge.
- No X propagation: every output is defined from the first reset edge onward.

Test Plan:
- Reset: Rst=1 for 1 edge, buttonPress=0 -> addr=0, newAddr=4, instruction=0 during reset; after Rst=0, instruction=32'h20080005.
- Hold: Rst=0, buttonPress=0 for 3 edges -> addr stays 0, instruction stays 32'h20080005.
- Single step: buttonPress=1 for exactly one rising edge, repeated 4 times with 3 idle edges between -> addr sequence 4, 8, 12, 16; instruction sequence 32'h2009000A, 32'h01095020, 32'h01095822, 32'h01096024; newAddr always addr+4.
- Continuous step: buttonPress=1 for 8 edges from addr=0 -> addr=32; instruction=0 (w8). Then step to addr=256 (beyond ROM) -> instruction=32'h00000000.
- Reset priority: buttonPress=1 and Rst=1 at an edge with addr=20 -> addr=0 at that edge; next edge with Rst=0 and buttonPress=1 -> addr=4.
- Wrap: force PC to 32'hFFFFFFFC through a verification-only path or a RESET_ADDR override, then step once -> newAddr was 0 and addr becomes 0, instruction=32'h20080005.
